// File: rtl/rom_load_ctrl.sv
// Purpose: packs iosys loader bytes into big-endian words, queues them and writes them to SDRAM port 1, then releases md_on.
// Latency: a completed word is pushed on its second byte; it is issued the next cycle when the FIFO head is free and no request is pending.
// Backpressure: none toward iosys; a word is dropped when the FIFO is full, and a byte past the ROM space is dropped; both set overflow.
// Optional: define ROM_CHECKSUM_EN to add o_checksum / o_checksum_ok (header checksum compare).
module rom_load_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_BITS  = 22
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [2:0]           i_loading,
  input  logic [7:0]           i_loader_do,
  input  logic                 i_loader_do_valid,
  output logic [ADDR_BITS-1:1] o_mem_addr,
  output logic [15:0]          o_mem_din,
  output logic [1:0]           o_mem_be,
  output logic                 o_mem_req,
  input  logic                 i_mem_ack,
  output logic                 o_md_on,
  output logic [ADDR_BITS-1:0] o_rom_size,
  output logic                 o_busy,
  output logic                 o_overflow
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [15:0]          o_checksum,
  output logic                 o_checksum_ok
`endif
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int WAW = ADDR_BITS - 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_RUN} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_ld;
  logic [ADDR_BITS:0]   r_cnt;        // byte counter, one extra bit so it can reach 2**ADDR_BITS
  logic                 r_half;
  logic [7:0]           r_hi;
  logic                 r_overflow;
  logic [PW:0]          r_wr_ptr, r_rd_ptr;
  logic [WAW-1:0]       r_fifo_addr [FIFO_DEPTH];
  logic [15:0]          r_fifo_din  [FIFO_DEPTH];
  logic [1:0]           r_fifo_be   [FIFO_DEPTH];
  logic [WAW-1:0]       r_mem_addr;
  logic [15:0]          r_mem_din;
  logic [1:0]           r_mem_be;
  logic                 r_mem_req;
  logic [ADDR_BITS-1:0] r_rom_size;

  logic           w_ld, w_start, w_stop;
  logic           w_empty, w_full, w_idle_bus;
  logic           w_byte, w_take, w_lim_drop, w_half_after;
  logic           w_push_full, w_push_pad, w_push, w_push_ok, w_push_drop;
  logic           w_issue, w_to_run;
  logic [7:0]     w_hi_eff;
  logic [15:0]    w_push_din;
  logic [1:0]     w_push_be;
  logic [WAW-1:0] w_push_addr;

  assign w_ld    = |i_loading;
  assign w_start = w_ld & ~r_ld;
  assign w_stop  = ~w_ld & r_ld;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_idle_bus = (i_mem_ack == r_mem_req);

  // A byte that arrives together with stop is still taken; the pad word then carries it.
  assign w_byte       = (r_state == S_LOAD) & i_loader_do_valid;
  assign w_take       = w_byte & ~r_cnt[ADDR_BITS];
  assign w_lim_drop   = w_byte & r_cnt[ADDR_BITS];
  assign w_half_after = r_half ^ w_take;
  assign w_push_full  = w_take & r_half;
  assign w_push_pad   = (r_state == S_LOAD) & w_stop & w_half_after;
  assign w_push       = w_push_full | w_push_pad;
  assign w_hi_eff     = r_half ? r_hi : i_loader_do;
  assign w_push_din   = w_push_full ? {r_hi, i_loader_do} : {w_hi_eff, 8'h00};
  assign w_push_be    = w_push_full ? 2'b11 : 2'b10;
  // The pair's first byte sits at an even count, so the word address is the count without bit 0.
  assign w_push_addr  = r_cnt[ADDR_BITS-1:1];

  // No issue on a start cycle: the FIFO is being flushed and its head is stale.
  assign w_issue     = ~w_empty & w_idle_bus & ~w_start;
  assign w_push_ok   = w_push & (~w_full | w_issue);
  assign w_push_drop = w_push & ~w_push_ok;

  // Next-state logic; start from any state restarts the load.
  always_comb begin
    w_state_nxt = r_state;
    w_to_run    = 1'b0;
    if (w_start) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:  if (w_stop) w_state_nxt = S_DRAIN;
        S_DRAIN: if (w_empty && w_idle_bus) begin
                   w_state_nxt = S_RUN;
                   w_to_run    = 1'b1;
                 end
        default: ;
      endcase
    end
  end

  // State register, byte packing, FIFO pointers and the SDRAM request toggle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_ld       <= 1'b0;
      r_cnt      <= '0;
      r_half     <= 1'b0;
      r_hi       <= 8'h00;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= 16'h0000;
      r_mem_be   <= 2'b00;
      r_mem_req  <= 1'b0;
      r_rom_size <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ld    <= w_ld;
      if (w_start) begin
        r_cnt      <= '0;
        r_half     <= 1'b0;
        r_overflow <= 1'b0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_take) begin
          r_cnt  <= r_cnt + (ADDR_BITS+1)'(1);
          r_half <= ~r_half;
          if (!r_half) r_hi <= i_loader_do;
        end
        if (w_push_pad) r_half <= 1'b0;
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
        if (w_issue) r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
        if (w_push_drop || w_lim_drop) r_overflow <= 1'b1;
      end
      if (w_issue) begin
        r_mem_addr <= r_fifo_addr[r_rd_ptr[PW-1:0]];
        r_mem_din  <= r_fifo_din[r_rd_ptr[PW-1:0]];
        r_mem_be   <= r_fifo_be[r_rd_ptr[PW-1:0]];
        r_mem_req  <= ~r_mem_req;
      end
      // A full-size image cannot be represented in the port; report all-ones rather than wrap to zero.
      if (w_to_run) r_rom_size <= r_cnt[ADDR_BITS] ? '1 : r_cnt[ADDR_BITS-1:0];
    end
  end

  // FIFO storage; emptiness is defined by the pointers, so the entries need no reset.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_fifo_addr[r_wr_ptr[PW-1:0]] <= w_push_addr;
      r_fifo_din[r_wr_ptr[PW-1:0]]  <= w_push_din;
      r_fifo_be[r_wr_ptr[PW-1:0]]   <= w_push_be;
    end
  end

  assign o_mem_addr = r_mem_addr;
  assign o_mem_din  = r_mem_din;
  assign o_mem_be   = r_mem_be;
  assign o_mem_req  = r_mem_req;
  assign o_md_on    = (r_state == S_RUN);
  assign o_rom_size = r_rom_size;
  assign o_busy     = (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign o_overflow = r_overflow;

`ifdef ROM_CHECKSUM_EN
  logic [15:0]          r_csum, r_hdr;
  logic                 r_csum_ok;
  logic [ADDR_BITS-1:0] w_push_byte_addr;

  assign w_push_byte_addr = {w_push_addr, 1'b0};

  // Sum the image body from 0x200 up and capture the header checksum word at 0x18E.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_start) begin
      r_csum    <= 16'h0000;
      r_hdr     <= 16'h0000;
      r_csum_ok <= 1'b0;
    end else begin
      if (w_push) begin
        if (w_push_byte_addr >= ADDR_BITS'('h200)) r_csum <= r_csum + w_push_din;
        if (w_push_byte_addr == ADDR_BITS'('h18E)) r_hdr <= w_push_din;
      end
      if (w_to_run) r_csum_ok <= (r_csum == r_hdr);
    end
  end

  assign o_checksum    = r_csum;
  assign o_checksum_ok = r_csum_ok;
`else
  // Checksum tracking not built.
`endif

endmodule
